// File: rtl/fft_peak_finder.sv
// Streaming FFT-bin peak finder: |X|^2 pipeline stage, running-max stage, and registered result.
// Optional build macro PEAK_MAG_OUT_EN adds the 64-bit winning magnitude output peak_mag.
module fft_peak_finder #(
    parameter int LOG2N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bin_valid,
    input  logic signed [31:0]      bin_re,
    input  logic signed [31:0]      bin_im,
    output logic                    done,
    output logic [LOG2N-1:0]        peak_idx,
    output logic                    busy
`ifdef PEAK_MAG_OUT_EN
    ,
    output logic [63:0]             peak_mag
`endif
);

    localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic               s1_valid_q;
    logic [LOG2N-1:0]   s1_idx_q;
    logic [63:0]        s1_mag_q;
    logic [63:0]        max_mag_q, max_mag_d;
    logic [LOG2N-1:0]   max_idx_q, max_idx_d;
    logic               last_q, last_d;
    logic               done_q;
    logic [LOG2N-1:0]   peak_idx_q, peak_idx_d;
    logic signed [63:0] re_sq_s, im_sq_s;
    logic [63:0]        mag_s;
    logic               take_s;

    // Squares of signed Q16.16 parts are non-negative and at most 2**62 each, so the sum fits unsigned 64.
    assign re_sq_s = $signed({{32{bin_re[31]}}, bin_re}) * $signed({{32{bin_re[31]}}, bin_re});
    assign im_sq_s = $signed({{32{bin_im[31]}}, bin_im}) * $signed({{32{bin_im[31]}}, bin_im});
    assign mag_s   = $unsigned(re_sq_s) + $unsigned(im_sq_s);

    // Next-state logic for counter, running max, result and control FSM.
    always_comb begin
        cnt_d      = cnt_q;
        max_mag_d  = max_mag_q;
        max_idx_d  = max_idx_q;
        last_d     = 1'b0;
        peak_idx_d = peak_idx_q;
        state_d    = state_q;
        take_s     = 1'b0;

        if (bin_valid) begin
            cnt_d = cnt_q + LOG2N'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Index 0 always restarts the frame; strict compare keeps the lowest index on ties.
        if (s1_valid_q) begin
            take_s = (s1_idx_q == '0) || (s1_mag_q > max_mag_q);
            last_d = (s1_idx_q == LAST_IDX);
        end else begin
            take_s = 1'b0;
            last_d = 1'b0;
        end

        if (take_s) begin
            max_mag_d = s1_mag_q;
            max_idx_d = s1_idx_q;
        end else begin
            max_mag_d = max_mag_q;
            max_idx_d = max_idx_q;
        end

        if (last_q) begin
            peak_idx_d = max_idx_q;
        end else begin
            peak_idx_d = peak_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bin_valid) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (s1_valid_q && (s1_idx_q == LAST_IDX) && !bin_valid) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_FLUSH: begin
                if (bin_valid) begin
                    state_d = ST_ACC;
                end else if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline, running max, result and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_mag_q   <= 64'd0;
            max_mag_q  <= 64'd0;
            max_idx_q  <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            peak_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= bin_valid;
            s1_idx_q   <= cnt_q;
            s1_mag_q   <= mag_s;
            max_mag_q  <= max_mag_d;
            max_idx_q  <= max_idx_d;
            last_q     <= last_d;
            done_q     <= last_q;
            peak_idx_q <= peak_idx_d;
        end
    end

`ifdef PEAK_MAG_OUT_EN
    logic [63:0] peak_mag_q;

    // Winning magnitude, captured alongside peak_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_mag_q <= 64'd0;
        end else if (last_q) begin
            peak_mag_q <= max_mag_q;
        end else begin
            peak_mag_q <= peak_mag_q;
        end
    end

    assign peak_mag = peak_mag_q;
`endif

    assign done     = done_q;
    assign peak_idx = peak_idx_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_peak_finder.sv
// Randomised scoreboard bench for fft_peak_finder; define PEAK_MAG_OUT_EN to also check peak_mag.
module tb_fft_peak_finder;
    localparam int LOG2N = 4;
    localparam int N     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bin_valid = 1'b0;
    logic signed [31:0] bin_re = 32'sd0;
    logic signed [31:0] bin_im = 32'sd0;
    logic              done;
    logic [LOG2N-1:0]  peak_idx;
    logic              busy;
`ifdef PEAK_MAG_OUT_EN
    logic [63:0]       peak_mag;
`endif

    fft_peak_finder #(.LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_re(bin_re), .bin_im(bin_im),
        .done(done), .peak_idx(peak_idx), .busy(busy)
`ifdef PEAK_MAG_OUT_EN
        , .peak_mag(peak_mag)
`endif
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              idx;
        longint unsigned mag;
        longint          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] fr_re[N];
    logic [31:0] fr_im[N];
    logic [31:0] small_v[4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference: exact |X|^2 via 64-bit arithmetic, first index of the maximum wins.
    function automatic exp_t model(input longint due);
        exp_t            r;
        longint          a, b;
        longint unsigned m;
        r.idx = 0; r.mag = 0; r.cyc = due;
        for (int i = 0; i < N; i++) begin
            a = longint'($signed(fr_re[i]));
            b = longint'($signed(fr_im[i]));
            m = longint'(unsigned'(a * a)) + longint'(unsigned'(b * b));
            if (i == 0 || m > r.mag) begin
                r.idx = i;
                r.mag = m;
            end
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("peak_idx", 64'(peak_idx), 64'(mon_e.idx));
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
`ifdef PEAK_MAG_OUT_EN
                chk("peak_mag", peak_mag, mon_e.mag);
`endif
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 32'd0;
            fr_im[i] = 32'd0;
        end
    endtask

    // Drive one frame; gap_pct randomly inserts idle cycles, alt forces exactly one idle per bin.
    task automatic send_frame(input int gap_pct, input bit alt, input bit chk_busy);
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                if (alt) begin
                    @(negedge clk);
                    if (chk_busy) chk("busy_gap", 64'(busy), 64'd1);
                    bin_valid = 1'b0; bin_re = $urandom; bin_im = $urandom;
                end else begin
                    while (int'($urandom_range(99)) < gap_pct) begin
                        @(negedge clk);
                        bin_valid = 1'b0; bin_re = $urandom; bin_im = $urandom;
                    end
                end
            end
            @(negedge clk);
            if (chk_busy && i > 0) chk("busy_bin", 64'(busy), 64'd1);
            bin_valid = 1'b1;
            bin_re    = fr_re[i];
            bin_im    = fr_im[i];
            if (i == N - 1) sb.push_back(model(cyc + 3));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bin_valid = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        small_v[0] = 32'h0000_0000; small_v[1] = 32'h0001_0000;
        small_v[2] = 32'hFFFF_0000; small_v[3] = 32'h0002_0000;

        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_peak_idx", 64'(peak_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        idle(2);

        // Single peak at bin 5: 3.0 + 4.0j -> 25.0
        clear_frame();
        fr_re[5] = 32'h0003_0000; fr_im[5] = 32'h0004_0000;
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        chk("single_peak_idx", 64'(peak_idx), 64'd5);
`ifdef PEAK_MAG_OUT_EN
        chk("single_peak_mag", peak_mag, 64'h0000_0019_0000_0000);
`endif

        // Tie between bins 3 and 9 keeps the lower index
        clear_frame();
        fr_re[3] = 32'h0001_0000; fr_re[9] = 32'h0001_0000;
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        chk("tie_idx", 64'(peak_idx), 64'd3);

        // Most negative components on bin 0
        clear_frame();
        fr_re[0] = 32'h8000_0000; fr_im[0] = 32'h8000_0000;
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        chk("maxneg_idx", 64'(peak_idx), 64'd0);
`ifdef PEAK_MAG_OUT_EN
        chk("maxneg_mag", peak_mag, 64'h8000_0000_0000_0000);
`endif

        // Back-to-back frames with peaks at 2 then 14
        clear_frame();
        fr_re[2] = 32'h0005_0000;
        send_frame(0, 1'b0, 1'b0);
        clear_frame();
        fr_im[14] = 32'hFFFA_0000;
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        chk("b2b_idx", 64'(peak_idx), 64'd14);

        // Alternating gaps, busy held through the frame and dropping after done
        clear_frame();
        for (int i = 0; i < N; i++) fr_re[i] = small_v[$urandom_range(3)];
        fr_im[7] = 32'h0003_0000;
        send_frame(0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            bin_valid = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                chk("busy_at_done", 64'(busy), 64'd1);
                @(negedge clk);
                chk("busy_after_done", 64'(busy), 64'd0);
            end
        end
        chk("gap_done_seen", 64'(seen), 64'd1);
        idle(3);

        // Reset in the middle of a frame discards it
        clear_frame();
        fr_re[3] = 32'h0009_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bin_valid = 1'b1; bin_re = fr_re[i]; bin_im = fr_im[i];
        end
        @(negedge clk);
        bin_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_peak_idx", 64'(peak_idx), 64'd0);
        rst = 1'b0;
        idle(2);
        clear_frame();
        fr_re[11] = 32'h0002_0000;
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        chk("after_rst_idx", 64'(peak_idx), 64'd11);

        // Randomised frames: full-range or tie-prone small values, random gaps and spacing
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f % 2 == 0) begin
                    fr_re[i] = $urandom; fr_im[i] = $urandom;
                end else begin
                    fr_re[i] = small_v[$urandom_range(3)];
                    fr_im[i] = small_v[$urandom_range(3)];
                end
            end
            send_frame(($urandom_range(1) == 1) ? 30 : 0, 1'b0, 1'b0);
            idle(int'($urandom_range(4)));
        end
        idle(1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
